imem_dmem_arbiter: RTL and testbench

//  Shares one req/rdy/valid memory port between the instruction fetcher (IF) and the load/store unit (LSU).

---
 rtl/imem_dmem_arbiter_pkg.sv | 30 +++
 rtl/imem_dmem_arbiter_pick.sv | 32 +++
 rtl/imem_dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : riscv_arb_pkg
// Brief   : Shared types for the IF/LSU memory-port arbiter.
//           Build option: define ARB_RR_EN for round-robin tie-breaking.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_arb_pkg;

  localparam int BE_W = 4;

`ifdef ARB_RR_EN
  localparam bit ARB_RR = 1'b1;
`else
  localparam bit ARB_RR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_LSU = 1'b1
  } arb_src_t;

endpackage
`default_nettype wire

// File: rtl/imem_dmem_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module  : arb_pick
// Brief   : Combinational winner selection between fetch and load/store.
//           Build option: ARB_RR_EN selects round-robin on ties.
// Revision: 1.0 - initial release
// ============================================================================
module arb_pick
  import riscv_arb_pkg::*;
(
  input  logic     if_req_i,
  input  logic     lsu_req_i,
  input  logic     starve_hit_i,
  input  arb_src_t last_grant_i,
  output arb_src_t winner_o
);

  always_comb begin
    winner_o = SRC_IF;
    if (if_req_i && lsu_req_i) begin
      if (ARB_RR) begin
        winner_o = (last_grant_i == SRC_IF) ? SRC_LSU : SRC_IF;
      end else begin
        winner_o = starve_hit_i ? SRC_IF : SRC_LSU;
      end
    end else if (lsu_req_i) begin
      winner_o = SRC_LSU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : imem_dmem_arbiter
// Brief   : Shares one req/rdy/valid memory port between fetch and LSU,
//           one transaction at a time. Build option: ARB_RR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [BITS-1:0] if_addr_i,
  output logic            if_rdy_o,
  output logic            if_valid_o,
  output logic [BITS-1:0] if_rdata_o,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [BE_W-1:0] lsu_be_i,
  input  logic [BITS-1:0] lsu_addr_i,
  input  logic [BITS-1:0] lsu_wdata_i,
  output logic            lsu_rdy_o,
  output logic            lsu_valid_o,
  output logic [BITS-1:0] lsu_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [BE_W-1:0] mem_be_o,
  output logic [BITS-1:0] mem_addr_o,
  output logic [BITS-1:0] mem_wdata_o,
  input  logic            mem_rdy_i,
  input  logic            mem_valid_i,
  input  logic [BITS-1:0] mem_rdata_i
);

  localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_MAX);
  // Round-robin never lets IF lose twice in a row, so the counter stays below the force threshold.
  localparam logic [7:0] C_STARVE_CAP = ARB_RR ? 8'(STARVE_MAX - 1) : 8'(STARVE_MAX);

  arb_state_t      state_q, state_d;
  arb_src_t        src_q, src_d;
  arb_src_t        last_grant_q, last_grant_d;
  logic [BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [7:0]      starve_cnt_q, starve_cnt_d;
  logic [BITS-1:0] if_rdata_q, if_rdata_d;
  logic [BITS-1:0] lsu_rdata_q, lsu_rdata_d;

  arb_src_t w_winner;
  logic     w_starve_hit;
  logic     w_decide;
  logic     w_accept;
  logic     w_deliver;

  assign w_starve_hit = (starve_cnt_q == C_STARVE_MAX);
  assign w_decide     = (state_q == IDLE) && (if_req_i || lsu_req_i);
  assign w_accept     = (state_q == ISSUE) && mem_rdy_i;
  assign w_deliver    = (state_q == WAIT) && mem_valid_i;

  arb_pick u_pick (
    .if_req_i     (if_req_i),
    .lsu_req_i    (lsu_req_i),
    .starve_hit_i (w_starve_hit),
    .last_grant_i (last_grant_q),
    .winner_o     (w_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      src_q        <= SRC_IF;
      last_grant_q <= SRC_IF;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      be_q         <= be_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req_i || lsu_req_i) state_d = ISSUE;
      ISSUE:   if (mem_rdy_i) state_d = WAIT;
      WAIT:    if (mem_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_d        = src_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    be_d         = be_q;
    starve_cnt_d = starve_cnt_q;
    if_rdata_d   = if_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    if (w_decide) begin
      src_d        = w_winner;
      last_grant_d = w_winner;
      if (w_winner == SRC_LSU) begin
        addr_d  = lsu_addr_i;
        wdata_d = lsu_wdata_i;
        we_d    = lsu_we_i;
        be_d    = lsu_be_i;
        if (if_req_i && (starve_cnt_q < C_STARVE_CAP)) starve_cnt_d = starve_cnt_q + 8'd1;
      end else begin
        addr_d       = if_addr_i;
        wdata_d      = '0;
        we_d         = 1'b0;
        be_d         = '1;
        starve_cnt_d = '0;
      end
    end
    if (w_deliver) begin
      if (src_q == SRC_IF) if_rdata_d = mem_rdata_i;
      else                 lsu_rdata_d = mem_rdata_i;
    end
  end

  always_comb begin
    mem_req_o   = (state_q == ISSUE);
    mem_we_o    = mem_req_o ? we_q    : 1'b0;
    mem_be_o    = mem_req_o ? be_q    : '0;
    mem_addr_o  = mem_req_o ? addr_q  : '0;
    mem_wdata_o = mem_req_o ? wdata_q : '0;
    if_rdy_o    = w_accept  && (src_q == SRC_IF);
    lsu_rdy_o   = w_accept  && (src_q == SRC_LSU);
    if_valid_o  = w_deliver && (src_q == SRC_IF);
    lsu_valid_o = w_deliver && (src_q == SRC_LSU);
    if_rdata_o  = if_valid_o  ? mem_rdata_i : if_rdata_q;
    lsu_rdata_o = lsu_valid_o ? mem_rdata_i : lsu_rdata_q;
  end

`ifndef SYNTHESIS
  // The owner of an in-flight request must keep it asserted until accepted.
  always @(posedge clk) begin
    if (!rst && state_q == ISSUE) begin
      assert ((src_q == SRC_IF) ? if_req_i : lsu_req_i);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_dmem_arbiter
// Brief   : Directed self-checking bench for imem_dmem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_rdy_o, if_valid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_rdy_o, lsu_valid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rdy_i, mem_valid_i;
  logic [31:0] mem_rdata_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.BITS(32), .STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdy_o    (if_rdy_o),
    .if_valid_o  (if_valid_o),
    .if_rdata_o  (if_rdata_o),
    .lsu_req_i   (lsu_req_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_be_i    (lsu_be_i),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_rdy_o   (lsu_rdy_o),
    .lsu_valid_o (lsu_valid_o),
    .lsu_rdata_o (lsu_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdy_i   (mem_rdy_i),
    .mem_valid_i (mem_valid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  cnt;
    bit  exp_if;
    rst = 1'b1;
    if_req_i = 0; if_addr_i = 0;
    lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0;
    mem_rdy_i = 0; mem_valid_i = 0; mem_rdata_i = 0;
    tick(); tick();

    // Reset state, stale mem_valid ignored in IDLE
    rst = 1'b0; mem_valid_i = 1; mem_rdata_i = 32'hAAAA5555;
    #2;
    chk("rst_mem_req",   32'(mem_req_o),   0);
    chk("rst_mem_addr",  mem_addr_o,       0);
    chk("rst_if_rdata",  if_rdata_o,       0);
    chk("rst_lsu_rdata", lsu_rdata_o,      0);
    tick();
    #2;
    chk("idle_if_valid",  32'(if_valid_o),  0);
    chk("idle_lsu_valid", 32'(lsu_valid_o), 0);
    chk("idle_mem_req",   32'(mem_req_o),   0);
    chk("idle_rdy",       32'(if_rdy_o | lsu_rdy_o), 0);

    // 1: single fetch
    tick(); mem_valid_i = 0; if_req_i = 1; if_addr_i = 32'h100; #2;
    chk("t1_c0_mem_req", 32'(mem_req_o), 0);
    tick(); #2;
    chk("t1_c1_mem_req",  32'(mem_req_o), 1);
    chk("t1_c1_mem_addr", mem_addr_o, 32'h100);
    chk("t1_c1_if_rdy",   32'(if_rdy_o), 0);
    tick(); mem_rdy_i = 1; #2;
    chk("t1_c2_if_rdy", 32'(if_rdy_o), 1);
    tick(); if_req_i = 0; mem_rdy_i = 0; #2;
    chk("t1_c3_mem_req",  32'(mem_req_o), 0);
    chk("t1_c3_if_valid", 32'(if_valid_o), 0);
    tick(); mem_valid_i = 1; mem_rdata_i = 32'h00500093; #2;
    chk("t1_c4_if_valid",  32'(if_valid_o), 1);
    chk("t1_c4_if_rdata",  if_rdata_o, 32'h00500093);
    chk("t1_c4_lsu_valid", 32'(lsu_valid_o), 0);
    tick(); mem_valid_i = 0; mem_rdata_i = 32'h0; #2;
    chk("t1_c5_if_valid", 32'(if_valid_o), 0);
    chk("t1_c5_if_hold",  if_rdata_o, 32'h00500093);
    chk("t1_c5_mem_addr", mem_addr_o, 0);

    // 2: simultaneous store and fetch; LSU first, IF after one IDLE cycle
    tick();
    if_req_i = 1; if_addr_i = 32'h104;
    lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'hF; lsu_addr_i = 32'h2000; lsu_wdata_i = 32'hDEADBEEF;
    #2;
    tick(); mem_rdy_i = 1; #2;
    chk("t2_lsu_addr",  mem_addr_o, 32'h2000);
    chk("t2_lsu_we",    32'(mem_we_o), 1);
    chk("t2_lsu_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("t2_lsu_be",    32'(mem_be_o), 32'hF);
    chk("t2_lsu_rdy",   32'(lsu_rdy_o), 1);
    chk("t2_if_rdy0",   32'(if_rdy_o), 0);
    tick(); lsu_req_i = 0; lsu_we_i = 0; mem_rdy_i = 0; mem_valid_i = 1; mem_rdata_i = 32'h0; #2;
    chk("t2_lsu_valid", 32'(lsu_valid_o), 1);
    chk("t2_if_valid0", 32'(if_valid_o), 0);
    tick(); mem_valid_i = 0; #2;
    chk("t2_gap_mem_req", 32'(mem_req_o), 0);
    tick(); mem_rdy_i = 1; #2;
    chk("t2_if_addr", mem_addr_o, 32'h104);
    chk("t2_if_we",   32'(mem_we_o), 0);
    chk("t2_if_rdy",  32'(if_rdy_o), 1);
    tick(); if_req_i = 0; mem_rdy_i = 0; mem_valid_i = 1; mem_rdata_i = 32'h12345678; #2;
    chk("t2_if_valid", 32'(if_valid_o), 1);
    chk("t2_if_rdata", if_rdata_o, 32'h12345678);
    tick(); mem_valid_i = 0; #2;

    // 4: memory stalls three cycles; mem_valid alongside mem_rdy ignored
    tick(); lsu_req_i = 1; lsu_we_i = 0; lsu_be_i = 4'h3; lsu_addr_i = 32'h3000; #2;
    for (int i = 0; i < 3; i++) begin
      tick(); mem_valid_i = 1; mem_rdata_i = 32'h00000BAD; #2;
      chk("t4_stall_req",  32'(mem_req_o), 1);
      chk("t4_stall_addr", mem_addr_o, 32'h3000);
      chk("t4_stall_rdy",  32'(lsu_rdy_o), 0);
      chk("t4_stall_val",  32'(lsu_valid_o), 0);
    end
    tick(); mem_rdy_i = 1; #2;
    chk("t4_rdy",       32'(lsu_rdy_o), 1);
    chk("t4_rdy_noval", 32'(lsu_valid_o), 0);
    chk("t4_be",        32'(mem_be_o), 32'h3);
    tick(); lsu_req_i = 0; mem_rdy_i = 0; mem_valid_i = 0; #2;
    chk("t4_wait_req", 32'(mem_req_o), 0);
    chk("t4_wait_val", 32'(lsu_valid_o), 0);
    tick(); mem_valid_i = 1; mem_rdata_i = 32'hCAFEF00D; #2;
    chk("t4_valid", 32'(lsu_valid_o), 1);
    chk("t4_rdata", lsu_rdata_o, 32'hCAFEF00D);
    tick(); mem_valid_i = 0; #2;

    // 3: both requesting continuously; starvation forcing or round-robin
    tick();
    if_req_i = 1; if_addr_i = 32'h400;
    lsu_req_i = 1; lsu_addr_i = 32'h5000; lsu_be_i = 4'hF;
    mem_rdy_i = 1; mem_valid_i = 1;
    cnt = 0;
    #2;
    for (int n = 1; n <= 10; n++) begin
`ifdef ARB_RR_EN
      exp_if = (n % 2 == 1);
`else
      exp_if = (cnt == 4);
      if (exp_if) cnt = 0;
      else        cnt++;
`endif
      mem_rdata_i = 32'h1000 + 32'(n);
      tick(); #2;
      chk("t3_if_rdy",  32'(if_rdy_o),  32'(exp_if));
      chk("t3_lsu_rdy", 32'(lsu_rdy_o), 32'(!exp_if));
      tick(); #2;
      chk("t3_if_valid",  32'(if_valid_o),  32'(exp_if));
      chk("t3_lsu_valid", 32'(lsu_valid_o), 32'(!exp_if));
      tick(); #2;
      chk("t3_idle_req", 32'(mem_req_o), 0);
    end
    if_req_i = 0; lsu_req_i = 0; mem_rdy_i = 0; mem_valid_i = 0;

    // 5: reset while waiting drops the response
    tick(); if_req_i = 1; if_addr_i = 32'h200; #2;
    tick(); mem_rdy_i = 1; #2;
    chk("t5_if_rdy", 32'(if_rdy_o), 1);
    tick(); if_req_i = 0; mem_rdy_i = 0; rst = 1; #2;
    chk("t5_wait_valid", 32'(if_valid_o), 0);
    tick(); rst = 0; mem_valid_i = 1; mem_rdata_i = 32'hFFFF0000; #2;
    chk("t5_post_if_valid",  32'(if_valid_o), 0);
    chk("t5_post_lsu_valid", 32'(lsu_valid_o), 0);
    chk("t5_post_mem_req",   32'(mem_req_o), 0);
    chk("t5_post_if_rdata",  if_rdata_o, 0);
    tick(); mem_valid_i = 0; #2;
    chk("t5_idle_mem_req", 32'(mem_req_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
